pci_cfg_regs: RTL and testbench

PCI_CFG_REGS -- requirements
Module: pci_cfg_regs

---
 rtl/pci_pkg.sv | 57 +++++
 rtl/pci_cfg_regs.sv | 157 +++++++++++++++
 tb/tb_pci_cfg_regs.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared PCI configuration-space definitions: dword offsets of the type-0
// header, capability constants, per-register write masks and the byte-lane
// merge helper used by every writable register.
package pci_pkg;

   // Dword offsets within the type-0 configuration header plus the MSI block
   typedef enum logic [5:0] {
      PCI_VID_DID     = 6'h00,
      PCI_CMD_STS     = 6'h01,
      PCI_CLASS_REV   = 6'h02,
      PCI_HDR         = 6'h03,
      PCI_BAR0        = 6'h04,
      PCI_BAR1        = 6'h05,
      PCI_BAR2        = 6'h06,
      PCI_BAR3        = 6'h07,
      PCI_BAR4        = 6'h08,
      PCI_BAR5        = 6'h09,
      PCI_CARDBUS_CIS = 6'h0a,
      PCI_SUBSYS      = 6'h0b,
      PCI_ROMBAR      = 6'h0c,
      PCI_CAPPTR      = 6'h0d,
      PCI_RSVD_0E     = 6'h0e,
      PCI_INTR        = 6'h0f,
      PCI_MSI_CTRL    = 6'h10,
      PCI_MSI_ADDR_LO = 6'h11,
      PCI_MSI_ADDR_HI = 6'h12,
      PCI_MSI_DATA    = 6'h13
   } pci_cfg_reg_offset;

   localparam logic [7:0] PCI_CAP_ID_MSI  = 8'h05;
   localparam logic [7:0] PCI_MSI_CAP_PTR = 8'h40;
   localparam logic [7:0] PCI_HDR_TYPE0   = 8'h00;

   // Writable-bit masks and read-only fields
   localparam logic [31:0] PCI_CMD_WMASK         = 32'h0000_0406;  // mem_en, bus master, intx disable
   localparam logic [31:0] PCI_STS_CAP_LIST      = 32'h0010_0000;  // status bit 20
   localparam logic [31:0] PCI_INTR_WMASK        = 32'h0000_00FF;  // interrupt line
   localparam logic [31:0] PCI_INTR_PIN_RO       = 32'h0000_0100;  // interrupt pin = INTA
   localparam logic [31:0] PCI_MSI_CTRL_WMASK    = 32'h0001_0000;  // MSI enable
   localparam logic [31:0] PCI_MSI_ADDR_LO_WMASK = 32'hFFFF_FFFC;  // dword-aligned address
   localparam logic [31:0] PCI_MSI_DATA_WMASK    = 32'h0000_FFFF;

   // Replace only the byte lanes whose enable bit is set
   function automatic logic [31:0] pci_be_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pci_cfg_regs.sv
// PCI type-0 configuration register block with a request/ack access port.
// Each access is taken in IDLE and acknowledged for exactly one cycle.
// Optional MSI capability: define PCI_MSI_EN to compile it in; without it
// the capability pointer and MSI registers read 0 and MSI outputs are tied 0.
module pci_cfg_regs
   import pci_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID      = 16'h1234,
   parameter logic [15:0] DEVICE_ID      = 16'h0001,
   parameter logic [31:0] CLASS_REV      = 32'h00FF0001,
   parameter int unsigned BAR0_SIZE_LOG2 = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_req,
   input  logic              cfg_we,
   input  pci_cfg_reg_offset cfg_addr,
   input  logic [3:0]        cfg_be,
   input  logic [31:0]       cfg_wdata,
   output logic              cfg_ack,
   output logic [31:0]       cfg_rdata,
   output logic [31:0]       bar0_base,
   output logic              mem_en,
   output logic              bus_master_en,
   output logic              intx_disable,
   output logic              msi_en,
   output logic [63:0]       msi_addr,
   output logic [15:0]       msi_data
);

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   // Low aperture bits of BAR0 are hardwired 0 (also encodes 32-bit, non-prefetchable memory)
   localparam logic [31:0] BAR0_MASK = ~((32'd1 << BAR0_SIZE_LOG2) - 32'd1);

`ifdef PCI_MSI_EN
   localparam logic [31:0] STS_RO = PCI_STS_CAP_LIST;
`else
   localparam logic [31:0] STS_RO = 32'h0;
`endif

   state_t      state_q, state_d;
   logic        wr_go, rd_go;
   logic [31:0] rd_val;
   logic [31:0] cfg_rdata_q;
   logic [31:0] cmd_q;
   logic [31:0] bar0_q;
   logic [31:0] intr_q;

   // An access is performed only on the edge that leaves IDLE
   assign wr_go = (state_q == ST_IDLE) && cfg_req &&  cfg_we;
   assign rd_go = (state_q == ST_IDLE) && cfg_req && !cfg_we;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a request moves to ACK, ACK always returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cfg_req) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode: acknowledge for the single cycle spent in ACK
   always_comb begin
      cfg_ack = 1'b0;
      if (state_q == ST_ACK) cfg_ack = 1'b1;
   end

`ifdef PCI_MSI_EN
   logic [31:0] msi_ctrl_q, msi_lo_q, msi_hi_q, msi_data_q;

   // MSI capability registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msi_ctrl_q <= 32'h0;
         msi_lo_q   <= 32'h0;
         msi_hi_q   <= 32'h0;
         msi_data_q <= 32'h0;
      end else if (wr_go) begin
         case (cfg_addr)
            PCI_MSI_CTRL:    msi_ctrl_q <= pci_be_merge(msi_ctrl_q, cfg_wdata, cfg_be) & PCI_MSI_CTRL_WMASK;
            PCI_MSI_ADDR_LO: msi_lo_q   <= pci_be_merge(msi_lo_q,   cfg_wdata, cfg_be) & PCI_MSI_ADDR_LO_WMASK;
            PCI_MSI_ADDR_HI: msi_hi_q   <= pci_be_merge(msi_hi_q,   cfg_wdata, cfg_be);
            PCI_MSI_DATA:    msi_data_q <= pci_be_merge(msi_data_q, cfg_wdata, cfg_be) & PCI_MSI_DATA_WMASK;
            default: ;
         endcase
      end
   end

   assign msi_en   = msi_ctrl_q[16];
   assign msi_addr = {msi_hi_q, msi_lo_q};
   assign msi_data = msi_data_q[15:0];
`else
   assign msi_en   = 1'b0;
   assign msi_addr = 64'h0;
   assign msi_data = 16'h0;
`endif

   // Read mux; unlisted offsets return 0
   always_comb begin
      rd_val = 32'h0;
      case (cfg_addr)
         PCI_VID_DID:     rd_val = {DEVICE_ID, VENDOR_ID};
         PCI_CMD_STS:     rd_val = cmd_q | STS_RO;
         PCI_CLASS_REV:   rd_val = CLASS_REV;
         PCI_HDR:         rd_val = {8'h00, PCI_HDR_TYPE0, 16'h0000};
         PCI_BAR0:        rd_val = bar0_q;
         PCI_SUBSYS:      rd_val = {DEVICE_ID, VENDOR_ID};
         PCI_INTR:        rd_val = intr_q | PCI_INTR_PIN_RO;
`ifdef PCI_MSI_EN
         PCI_CAPPTR:      rd_val = {24'h0, PCI_MSI_CAP_PTR};
         PCI_MSI_CTRL:    rd_val = msi_ctrl_q | {8'h00, 8'h80, 8'h00, PCI_CAP_ID_MSI};
         PCI_MSI_ADDR_LO: rd_val = msi_lo_q;
         PCI_MSI_ADDR_HI: rd_val = msi_hi_q;
         PCI_MSI_DATA:    rd_val = msi_data_q;
`endif
         default:         rd_val = 32'h0;
      endcase
   end

   // Header registers and registered read data (cleared outside the ack cycle)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q       <= 32'h0;
         bar0_q      <= 32'h0;
         intr_q      <= 32'h0;
         cfg_rdata_q <= 32'h0;
      end else begin
         cfg_rdata_q <= rd_go ? rd_val : 32'h0;
         if (wr_go) begin
            case (cfg_addr)
               PCI_CMD_STS: cmd_q  <= pci_be_merge(cmd_q,  cfg_wdata, cfg_be) & PCI_CMD_WMASK;
               PCI_BAR0:    bar0_q <= pci_be_merge(bar0_q, cfg_wdata, cfg_be) & BAR0_MASK;
               PCI_INTR:    intr_q <= pci_be_merge(intr_q, cfg_wdata, cfg_be) & PCI_INTR_WMASK;
               default: ;
            endcase
         end
      end
   end

   assign cfg_rdata     = cfg_rdata_q;
   assign bar0_base     = bar0_q;
   assign mem_en        = cmd_q[1];
   assign bus_master_en = cmd_q[2];
   assign intx_disable  = cmd_q[10];

endmodule

// File: tb/tb_pci_cfg_regs.sv
// Testbench for pci_cfg_regs: directed checks followed by random accesses
// compared against a table-driven model of the configuration space
// (stored value, writable mask and read-only bits per dword offset).
// Honours PCI_MSI_EN the same way as the design.
module tb_pci_cfg_regs;
   import pci_pkg::*;

   localparam int BAR_LOG2 = 12;
`ifdef PCI_MSI_EN
   localparam bit MSI = 1'b1;
`else
   localparam bit MSI = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              cfg_req;
   logic              cfg_we;
   pci_cfg_reg_offset cfg_addr;
   logic [3:0]        cfg_be;
   logic [31:0]       cfg_wdata;
   logic              cfg_ack;
   logic [31:0]       cfg_rdata;
   logic [31:0]       bar0_base;
   logic              mem_en;
   logic              bus_master_en;
   logic              intx_disable;
   logic              msi_en;
   logic [63:0]       msi_addr;
   logic [15:0]       msi_data;

   pci_cfg_regs #(
      .VENDOR_ID      (16'h1234),
      .DEVICE_ID      (16'h0001),
      .CLASS_REV      (32'h00FF0001),
      .BAR0_SIZE_LOG2 (BAR_LOG2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_req       (cfg_req),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_be        (cfg_be),
      .cfg_wdata     (cfg_wdata),
      .cfg_ack       (cfg_ack),
      .cfg_rdata     (cfg_rdata),
      .bar0_base     (bar0_base),
      .mem_en        (mem_en),
      .bus_master_en (bus_master_en),
      .intx_disable  (intx_disable),
      .msi_en        (msi_en),
      .msi_addr      (msi_addr),
      .msi_data      (msi_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   logic [31:0] m_val [64];
   logic [31:0] m_wm  [64];
   logic [31:0] m_ro  [64];

   int unsigned picks [20] = '{0, 1, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 40, 63};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Configuration space description: what each offset returns and which bits a write can change
   task automatic model_init();
      for (int a = 0; a < 64; a++) begin
         m_val[a] = 32'h0;
         m_wm[a]  = 32'h0;
         m_ro[a]  = 32'h0;
      end
      m_ro[6'h00] = 32'h0001_1234;
      m_ro[6'h01] = MSI ? 32'h0010_0000 : 32'h0;
      m_wm[6'h01] = 32'h0000_0406;
      m_ro[6'h02] = 32'h00FF_0001;
      m_ro[6'h03] = 32'h0000_0000;
      m_wm[6'h04] = ~((32'd1 << BAR_LOG2) - 32'd1);
      m_ro[6'h0b] = 32'h0001_1234;
      m_ro[6'h0f] = 32'h0000_0100;
      m_wm[6'h0f] = 32'h0000_00FF;
      if (MSI) begin
         m_ro[6'h0d] = 32'h0000_0040;
         m_ro[6'h10] = 32'h0080_0005;
         m_wm[6'h10] = 32'h0001_0000;
         m_wm[6'h11] = 32'hFFFF_FFFC;
         m_wm[6'h12] = 32'hFFFF_FFFF;
         m_wm[6'h13] = 32'h0000_FFFF;
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < 64; a++) m_val[a] = 32'h0;
   endtask

   function automatic logic [31:0] model_read(input int a);
      return (m_val[a] & m_wm[a]) | m_ro[a];
   endfunction

   task automatic model_write(input int a, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] lane;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            lane = (32'hFF << (8 * b)) & m_wm[a];
            m_val[a] = (m_val[a] & ~lane) | (wd & lane);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] cmd;
      cmd = m_val[1];
      check({tag, "_mem_en"},   mem_en,        cmd[1]);
      check({tag, "_bme"},      bus_master_en, cmd[2]);
      check({tag, "_intx_dis"}, intx_disable,  cmd[10]);
      check({tag, "_bar0"},     bar0_base,     m_val[4]);
      check({tag, "_msi_en"},   msi_en,        m_val[16][16]);
      check({tag, "_msi_addr"}, msi_addr,      {m_val[18], m_val[17]});
      check({tag, "_msi_data"}, msi_data,      m_val[19][15:0]);
   endtask

   // One request/ack transaction; ack must appear in the cycle after the capturing edge
   task automatic access(input bit we, input logic [5:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input string tag);
      int          n;
      bit          got;
      logic [31:0] rd;
      @(negedge clk);
      check({tag, "_idle_ack"},   cfg_ack,   1'b0);
      check({tag, "_idle_rdata"}, cfg_rdata, 32'h0);
      cfg_req   = 1'b1;
      cfg_we    = we;
      cfg_addr  = pci_cfg_reg_offset'(a);
      cfg_be    = be;
      cfg_wdata = wd;
      n   = 0;
      got = 1'b0;
      rd  = 32'h0;
      while (n < 8 && !got) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (cfg_ack === 1'b1) begin
            got = 1'b1;
            rd  = cfg_rdata;
         end
      end
      cfg_req = 1'b0;
      check({tag, "_ack_lat"}, n, 1);
      n_txn++;
      if (we) begin
         model_write(int'(a), be, wd);
         check_outputs(tag);
      end else begin
         check({tag, "_rdata"}, rd, model_read(int'(a)));
      end
      $display("txn %0d %s %s addr=%h be=%h wdata=%h rdata=%h", n_txn, tag,
               we ? "WR" : "RD", a, be, wd, rd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  ra;
      logic [31:0] wd;
      rst_n     = 1'b0;
      cfg_req   = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = PCI_VID_DID;
      cfg_be    = 4'h0;
      cfg_wdata = 32'h0;
      model_init();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack",   cfg_ack,   1'b0);
      check("rst_rdata", cfg_rdata, 32'h0);
      check_outputs("rst");
      rst_n = 1'b1;

      // Identification read after reset
      access(1'b0, 6'h00, 4'hF, 32'h0, "vid_did");
      // BAR0 sizing
      access(1'b1, 6'h04, 4'hF, 32'hFFFF_FFFF, "bar0_wr");
      access(1'b0, 6'h04, 4'hF, 32'h0, "bar0_rd");
      check("bar0_size", bar0_base, 32'hFFFF_F000);
      // Command register: only bits 1, 2, 10 stick
      access(1'b1, 6'h01, 4'hF, 32'hFFFF_FFFF, "cmd_wr");
      access(1'b0, 6'h01, 4'hF, 32'h0, "cmd_rd");
      check("cmd_bits", {mem_en, bus_master_en, intx_disable}, 3'b111);
      // Partial byte enables into MSI upper address
      access(1'b1, 6'h12, 4'b0011, 32'hDEAD_BEEF, "msi_hi_wr");
      access(1'b0, 6'h12, 4'hF, 32'h0, "msi_hi_rd");
      // Byte-enable 0 write changes nothing
      access(1'b1, 6'h0f, 4'h0, 32'hFFFF_FFFF, "be0_wr");
      access(1'b0, 6'h0f, 4'hF, 32'h0, "intr_rd");
      // Remaining read-only header fields
      access(1'b0, 6'h02, 4'hF, 32'h0, "class_rev");
      access(1'b0, 6'h03, 4'hF, 32'h0, "hdr_type");
      access(1'b0, 6'h0b, 4'hF, 32'h0, "subsys");
      access(1'b0, 6'h0d, 4'hF, 32'h0, "capptr");
      access(1'b0, 6'h10, 4'hF, 32'h0, "msi_ctrl");

      // Request held continuously: acks every second cycle
      @(negedge clk);
      cfg_req  = 1'b1;
      cfg_we   = 1'b0;
      cfg_addr = PCI_VID_DID;
      cfg_be   = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("b2b_ack",   cfg_ack,   (i % 2 == 0) ? 1'b1 : 1'b0);
         check("b2b_rdata", cfg_rdata, (i % 2 == 0) ? 32'h0001_1234 : 32'h0);
      end
      cfg_req = 1'b0;

      // Random traffic against the model
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 3) == 0) ra = 6'($urandom_range(0, 63));
         else                           ra = 6'(picks[$urandom_range(0, 19)]);
         wd = $urandom;
         if ($urandom_range(0, 1) == 1) access(1'b1, ra, 4'($urandom_range(0, 15)), wd, "rnd_wr");
         else                           access(1'b0, ra, 4'hF, 32'h0, "rnd_rd");
      end

      // Reset asserted while an acknowledge is in flight
      @(negedge clk);
      cfg_req   = 1'b1;
      cfg_we    = 1'b1;
      cfg_addr  = PCI_CMD_STS;
      cfg_be    = 4'hF;
      cfg_wdata = 32'h0000_0406;
      @(posedge clk);
      @(negedge clk);
      cfg_req = 1'b0;
      check("rstack_pre_ack", cfg_ack, 1'b1);
      check("rstack_pre_mem", mem_en,  1'b1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rstack_ack",   cfg_ack,   1'b0);
      check("rstack_rdata", cfg_rdata, 32'h0);
      check_outputs("rstack");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstack_no_ack", cfg_ack, 1'b0);
      end
      access(1'b0, 6'h01, 4'hF, 32'h0, "post_rst_cmd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
